// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_pkg
//  Description : Shared constants and types for the 7-segment scan driver.
//                Segment order is {g,f,e,d,c,b,a}, active-low.
//  Revision    : 1.0 - initial release
// ============================================================================
package seg7_pkg;

    // All segments dark
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Hex glyphs 0-9, A, b, C, d, E, F (active-low)
    localparam logic [6:0] SEG_HEX [0:15] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    // Anode vector for the standard 4-digit board
    localparam int DIGITS_DEFAULT = 4;
    typedef logic [DIGITS_DEFAULT-1:0] anode_t;

    // Scan FSM: anodes-off gap, then drive the current digit
    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/seg7_hex_decode.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_hex_decode
//  Description : Combinational nibble to active-low 7-segment glyph lookup.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = SEG_HEX[nibble];

endmodule
`default_nettype wire

// File: rtl/seg7_scan.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan
//  Description : Time-multiplexed driver for a common-anode 7-segment display.
//                One digit per scan_tick, anode-off blanking gap after every
//                digit switch, tear-free shadow/active value committed at
//                frame start, optional leading-zero suppression.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scan_tick,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  data_valid,
    input  logic                  lz_en,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] c_last_idx   = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] c_blank_init = CNT_W'(BLANK_CYCLES);

    scan_state_t           r_state;
    logic [CNT_W-1:0]      r_blank_cnt;
    logic [IDX_W-1:0]      r_idx;
    logic [4*DIGITS-1:0]   r_shadow_data;
    logic [DIGITS-1:0]     r_shadow_dp;
    logic                  r_pending;
    logic [4*DIGITS-1:0]   r_active_data;
    logic [DIGITS-1:0]     r_active_dp;

    logic                  w_wrap;
    logic                  w_commit;
    logic [IDX_W-1:0]      w_next_idx;
    logic [4*DIGITS-1:0]   w_act_data_nxt;
    logic [DIGITS-1:0]     w_act_dp_nxt;
    logic [3:0]            w_nibble;
    logic [6:0]            w_seg_pat;
    logic [DIGITS-1:0]     w_suppress;
    logic [DIGITS-1:0]     w_onehot;
    logic [DIGITS-1:0]     w_drive_an;

    // The commit happens on the same edge the index wraps, so the pattern
    // loaded into seg/dp must already see the newly committed value.
    assign w_wrap         = scan_tick && (r_idx == c_last_idx);
    assign w_commit       = w_wrap && r_pending;
    assign w_next_idx     = !scan_tick ? r_idx : (w_wrap ? '0 : r_idx + 1'b1);
    assign w_act_data_nxt = w_commit ? r_shadow_data : r_active_data;
    assign w_act_dp_nxt   = w_commit ? r_shadow_dp   : r_active_dp;
    assign w_nibble       = w_act_data_nxt[{w_next_idx, 2'b00} +: 4];

    seg7_hex_decode u_decode (
        .nibble (w_nibble),
        .seg    (w_seg_pat)
    );

    // A digit is dark when it and every higher digit are zero with no
    // decimal point lit at or above it; digit 0 always shows.
    assign w_suppress[0] = 1'b0;
    for (genvar gi = 1; gi < DIGITS; gi++) begin : g_suppress
        assign w_suppress[gi] = lz_en
                             && (r_active_data[4*DIGITS-1:4*gi] == '0)
                             && (r_active_dp[DIGITS-1:gi] == '0);
    end

    assign w_onehot   = DIGITS'(1) << r_idx;
    assign w_drive_an = w_suppress[r_idx] ? '1 : ~w_onehot;

    // Shadow register takes writes; active register changes only at frame start
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_shadow_data <= '0;
            r_shadow_dp   <= '0;
            r_pending     <= 1'b0;
            r_active_data <= '0;
            r_active_dp   <= '0;
        end else begin
            if (data_valid) begin
                r_shadow_data <= data_in;
                r_shadow_dp   <= dp_in;
                r_pending     <= 1'b1;
            end else if (w_commit) begin
                r_pending     <= 1'b0;
            end
            if (w_commit) begin
                r_active_data <= r_shadow_data;
                r_active_dp   <= r_shadow_dp;
            end
        end
    end

    // Scan FSM, digit index, blanking counter and registered display outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_BLANK;
            r_blank_cnt <= c_blank_init;
            r_idx       <= '0;
            an          <= '1;
            seg         <= SEG_OFF;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_wrap;
            seg         <= w_seg_pat;
            dp          <= ~w_act_dp_nxt[w_next_idx];
            r_idx       <= w_next_idx;
            if (scan_tick) begin
                // A tick always restarts the gap, even mid-gap
                r_state     <= ST_BLANK;
                r_blank_cnt <= c_blank_init;
                an          <= '1;
            end else begin
                case (r_state)
                    ST_BLANK: begin
                        if (r_blank_cnt == '0) begin
                            r_state <= ST_DRIVE;
                            an      <= w_drive_an;
                        end else begin
                            r_blank_cnt <= r_blank_cnt - 1'b1;
                            an          <= '1;
                        end
                    end
                    default: begin
                        an <= w_drive_an;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
